// File: rtl/flag_unit_pipe.sv
// flag_unit_pipe: pipelined NZCV flag generator.
// Zero detection is an OR-reduction tree of GATE_FANIN-input gates with a
// register after every LEVELS_PER_STAGE tree levels; N/C/V/set_flags ride
// alongside as sideband. The architectural flags update on the edge that
// retires an op marked set_flags.
// Optional: define FLAG_UNIT_PARITY_EN to add flag_p (XOR of all result bits)
// from a parallel XOR tree with identical shape and latency.
module flag_unit_pipe #(
  parameter int WIDTH            = 64,
  parameter int GATE_FANIN       = 4,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             overflow_in,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_zero,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
`ifdef FLAG_UNIT_PARITY_EN
  ,
  output logic             flag_p
`endif
);

  function automatic int lvl_width(int lvl);
    int w;
    w = WIDTH;
    for (int i = 0; i < lvl; i++) w = (w + GATE_FANIN - 1) / GATE_FANIN;
    return w;
  endfunction

  function automatic int num_levels();
    int w;
    int n;
    w = WIDTH;
    n = 0;
    while (w > 1) begin
      w = (w + GATE_FANIN - 1) / GATE_FANIN;
      n++;
    end
    return n;
  endfunction

  localparam int LEVELS = num_levels();
  localparam int L      = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Reduction tree: each level zero-pads its input to whole gates, then
  // reduces each gate. Levels that close a stage are followed by a register.
  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int WI      = lvl_width(i);
    localparam int WO      = lvl_width(i + 1);
    localparam bit REG_OUT = (((i + 1) % LEVELS_PER_STAGE) == 0) || ((i + 1) == LEVELS);

    logic [WI-1:0]            din;
    logic [WO*GATE_FANIN-1:0] pad;
    logic [WO-1:0]            dout;
`ifdef FLAG_UNIT_PARITY_EN
    logic [WI-1:0]            pdin;
    logic [WO*GATE_FANIN-1:0] ppad;
    logic [WO-1:0]            pdout;
`endif

    if (i == 0) begin : g_src
      assign din  = result;
`ifdef FLAG_UNIT_PARITY_EN
      assign pdin = result;
`endif
    end else if ((i % LEVELS_PER_STAGE) == 0) begin : g_src
      assign din  = g_lvl[i-1].g_reg.q;
`ifdef FLAG_UNIT_PARITY_EN
      assign pdin = g_lvl[i-1].g_reg.pq;
`endif
    end else begin : g_src
      assign din  = g_lvl[i-1].dout;
`ifdef FLAG_UNIT_PARITY_EN
      assign pdin = g_lvl[i-1].pdout;
`endif
    end

    assign pad = (WO*GATE_FANIN)'(din);

    // OR each gate-sized group of this level
    always_comb begin
      dout = '0;
      for (int unsigned j = 0; j < WO; j++) dout[j] = |pad[j*GATE_FANIN +: GATE_FANIN];
    end

`ifdef FLAG_UNIT_PARITY_EN
    assign ppad = (WO*GATE_FANIN)'(pdin);

    // XOR each gate-sized group of this level
    always_comb begin
      pdout = '0;
      for (int unsigned j = 0; j < WO; j++) pdout[j] = ^ppad[j*GATE_FANIN +: GATE_FANIN];
    end
`endif

    if (REG_OUT) begin : g_reg
      logic [WO-1:0] q;
`ifdef FLAG_UNIT_PARITY_EN
      logic [WO-1:0] pq;
`endif
      // Partial-reduction register; contents are only meaningful when the
      // matching valid bit is set, so no reset is needed
      always_ff @(posedge clk) begin
        q  <= dout;
`ifdef FLAG_UNIT_PARITY_EN
        pq <= pdout;
`endif
      end
    end
  end

  logic [L-1:0] vld_q;
  logic         last_vld_d;
  logic         last_n_d;
  logic         last_c_d;
  logic         last_v_d;
  logic         last_s_d;
  logic         upd;

  // Stage valid bits: flush kills everything in flight and the incoming op
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid & ~flush;
      for (int unsigned s = 1; s < L; s++) vld_q[s] <= vld_q[s-1] & ~flush;
    end
  end

  // Sideband only needs registering up to the stage before the last; the
  // final edge writes straight into the flag register.
  if (L > 1) begin : g_sb
    logic [L-2:0] n_q;
    logic [L-2:0] c_q;
    logic [L-2:0] v_q;
    logic [L-2:0] s_q;

    // Sideband shift register tracking the tree stages
    always_ff @(posedge clk) begin
      if (!reset) begin
        n_q <= '0;
        c_q <= '0;
        v_q <= '0;
        s_q <= '0;
      end else begin
        n_q[0] <= result[WIDTH-1];
        c_q[0] <= carry_in;
        v_q[0] <= overflow_in;
        s_q[0] <= set_flags;
        for (int unsigned s = 1; s < L - 1; s++) begin
          n_q[s] <= n_q[s-1];
          c_q[s] <= c_q[s-1];
          v_q[s] <= v_q[s-1];
          s_q[s] <= s_q[s-1];
        end
      end
    end

    assign last_vld_d = vld_q[L-2];
    assign last_n_d   = n_q[L-2];
    assign last_c_d   = c_q[L-2];
    assign last_v_d   = v_q[L-2];
    assign last_s_d   = s_q[L-2];
  end else begin : g_sb
    assign last_vld_d = in_valid;
    assign last_n_d   = result[WIDTH-1];
    assign last_c_d   = carry_in;
    assign last_v_d   = overflow_in;
    assign last_s_d   = set_flags;
  end

  assign upd = last_vld_d & ~flush & last_s_d;

  // Architectural flags: written on the edge that retires a set_flags op
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
`ifdef FLAG_UNIT_PARITY_EN
      flag_p <= 1'b0;
`endif
    end else if (upd) begin
      flag_n <= last_n_d;
      flag_z <= ~g_lvl[LEVELS-1].dout[0];
      flag_c <= last_c_d;
      flag_v <= last_v_d;
`ifdef FLAG_UNIT_PARITY_EN
      flag_p <= g_lvl[LEVELS-1].pdout[0];
`endif
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_zero  = vld_q[L-1] & ~g_lvl[LEVELS-1].g_reg.q[0];

endmodule

// File: tb/tb_flag_unit_pipe.sv
// Directed self-checking bench for flag_unit_pipe: default configuration
// (L=3) plus two parameter variants (32/4/2 -> L=2, 16/2/1 -> L=4).
module tb_flag_unit_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] result;
  logic        carry_in;
  logic        overflow_in;
  logic        set_flags;
  logic        flush;
  logic        out_valid, out_zero, flag_n, flag_z, flag_c, flag_v;

  logic [31:0] res_b;
  logic        ov_b, oz_b, fn_b, fz_b, fc_b, fv_b;
  logic [15:0] res_c;
  logic        ov_c, oz_c, fn_c, fz_c, fc_c, fv_c;
`ifdef FLAG_UNIT_PARITY_EN
  logic        fp_a, fp_b, fp_c;
`endif

  int errors = 0;
  int checks = 0;

  flag_unit_pipe dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .result(result),
    .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags), .flush(flush),
    .out_valid(out_valid), .out_zero(out_zero),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`ifdef FLAG_UNIT_PARITY_EN
    , .flag_p(fp_a)
`endif
  );

  flag_unit_pipe #(.WIDTH(32), .GATE_FANIN(4), .LEVELS_PER_STAGE(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .result(res_b),
    .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov_b), .out_zero(oz_b),
    .flag_n(fn_b), .flag_z(fz_b), .flag_c(fc_b), .flag_v(fv_b)
`ifdef FLAG_UNIT_PARITY_EN
    , .flag_p(fp_b)
`endif
  );

  flag_unit_pipe #(.WIDTH(16), .GATE_FANIN(2), .LEVELS_PER_STAGE(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .result(res_c),
    .carry_in(carry_in), .overflow_in(overflow_in), .set_flags(set_flags), .flush(flush),
    .out_valid(ov_c), .out_zero(oz_c),
    .flag_n(fn_c), .flag_z(fz_c), .flag_c(fc_c), .flag_v(fv_c)
`ifdef FLAG_UNIT_PARITY_EN
    , .flag_p(fp_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic sf, input logic c, input logic ov);
    in_valid    = v;
    result      = r;
    set_flags   = sf;
    carry_in    = c;
    overflow_in = ov;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    res_b = '1;
    res_c = '1;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    cyc();
    cyc();
    checks++;
    if ({out_valid, out_zero, flag_n, flag_z, flag_c, flag_v} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {out_valid, out_zero, flag_n, flag_z, flag_c, flag_v});
    end
    checks++;
    if ({ov_b, oz_b, fz_b, ov_c, oz_c, fz_c} !== 6'b0) begin
      errors++;
      $display("FAIL reset_variants: got %b expected 000000", {ov_b, oz_b, fz_b, ov_c, oz_c, fz_c});
    end
    reset = 1'b1;
    res_b = '0;
    res_c = '0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic test_latency();
    drive(1'b1, 64'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 2; n++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early_%0d: got out_valid=%b expected 0", n, out_valid);
      end
      cyc();
    end
    checks++;
    if ({out_valid, out_zero} !== 2'b11) begin
      errors++;
      $display("FAIL latency_out: got valid,zero=%b expected 11", {out_valid, out_zero});
    end
    checks++;
    if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
      errors++;
      $display("FAIL latency_flags: got nzcv=%b expected 0110", {flag_n, flag_z, flag_c, flag_v});
    end
    cyc();
    checks++;
    if ({out_valid, out_zero, flag_z} !== 3'b001) begin
      errors++;
      $display("FAIL latency_after: got valid,zero,z=%b expected 001", {out_valid, out_zero, flag_z});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_f [3];
    exp_f[0] = 4'b0001;
    exp_f[1] = 4'b1010;
    exp_f[2] = 4'b0011;
    drive(1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 64'h0000_0100_0000_0000, 1'b1, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_zero} !== 2'b10) begin
        errors++;
        $display("FAIL leaf_out_%0d: got valid,zero=%b expected 10", k, {out_valid, out_zero});
      end
      checks++;
      if ({flag_n, flag_z, flag_c, flag_v} !== exp_f[k]) begin
        errors++;
        $display("FAIL leaf_flags_%0d: got nzcv=%b expected %b", k,
                 {flag_n, flag_z, flag_c, flag_v}, exp_f[k]);
      end
      cyc();
    end
  endtask

  task automatic test_set_flags_gating();
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 64'h5, 1'b0, 1'b1, 1'b1);
    cyc();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    checks++;
    if ({out_valid, out_zero, flag_n, flag_z, flag_c, flag_v} !== 6'b110100) begin
      errors++;
      $display("FAIL gating_a: got valid,zero,nzcv=%b expected 110100",
               {out_valid, out_zero, flag_n, flag_z, flag_c, flag_v});
    end
    cyc();
    checks++;
    if ({out_valid, out_zero, flag_n, flag_z, flag_c, flag_v} !== 6'b100100) begin
      errors++;
      $display("FAIL gating_b: got valid,zero,nzcv=%b expected 100100",
               {out_valid, out_zero, flag_n, flag_z, flag_c, flag_v});
    end
    cyc();
    checks++;
    if ({out_valid, out_zero} !== 2'b00) begin
      errors++;
      $display("FAIL gating_idle: got valid,zero=%b expected 00", {out_valid, out_zero});
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre1: got out_valid=%b expected 0", out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre2: got out_valid=%b expected 0", out_valid);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    // the op issued right after the flush must proceed normally
    cyc();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      if (n == 2) begin
        checks++;
        if ({out_valid, out_zero, flag_n, flag_z, flag_c, flag_v} !== 6'b101011) begin
          errors++;
          $display("FAIL flush_next_op: got valid,zero,nzcv=%b expected 101011",
                   {out_valid, out_zero, flag_n, flag_z, flag_c, flag_v});
        end
      end else begin
        checks++;
        if ({out_valid, flag_n, flag_z, flag_c, flag_v} !== 5'b00100) begin
          errors++;
          $display("FAIL flush_killed_%0d: got valid,nzcv=%b expected 00100", n,
                   {out_valid, flag_n, flag_z, flag_c, flag_v});
        end
        cyc();
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid_flight();
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc();
    cyc();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    checks++;
    if ({out_valid, out_zero, flag_n, flag_z, flag_c, flag_v} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_clear: got %b expected 000000",
               {out_valid, out_zero, flag_n, flag_z, flag_c, flag_v});
    end
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++;
      if ({out_valid, flag_n, flag_z, flag_c, flag_v} !== 5'b0) begin
        errors++;
        $display("FAIL midreset_lost_%0d: got valid,nzcv=%b expected 00000", n,
                 {out_valid, flag_n, flag_z, flag_c, flag_v});
      end
    end
  endtask

  task automatic test_param_sweep();
    logic exp_vb, exp_zb, exp_vc, exp_zc;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) cyc();
    for (int n = 1; n <= 7; n++) begin
      case (n)
        1: begin in_valid = 1'b1; set_flags = 1'b1; res_b = 32'h0;        res_c = 16'h0;    end
        2: begin in_valid = 1'b1; set_flags = 1'b1; res_b = 32'h1;        res_c = 16'h1;    end
        3: begin in_valid = 1'b1; set_flags = 1'b1; res_b = 32'hFFFF_FFFF; res_c = 16'hFFFF; end
        default: begin in_valid = 1'b0; set_flags = 1'b0; end
      endcase
      cyc();
      exp_vb = (n >= 2) && (n <= 4);
      exp_zb = (n == 2);
      exp_vc = (n >= 4) && (n <= 6);
      exp_zc = (n == 4);
      checks++;
      if ({ov_b, oz_b} !== {exp_vb, exp_zb}) begin
        errors++;
        $display("FAIL sweep_w32_c%0d: got valid,zero=%b expected %b", n, {ov_b, oz_b}, {exp_vb, exp_zb});
      end
      checks++;
      if ({ov_c, oz_c} !== {exp_vc, exp_zc}) begin
        errors++;
        $display("FAIL sweep_w16_c%0d: got valid,zero=%b expected %b", n, {ov_c, oz_c}, {exp_vc, exp_zc});
      end
      if (n == 2 || n == 3) begin
        checks++;
        if (fz_b !== (n == 2)) begin
          errors++;
          $display("FAIL sweep_w32_flagz_c%0d: got %b expected %b", n, fz_b, (n == 2));
        end
      end
      if (n == 4 || n == 6) begin
        checks++;
        if ({fn_c, fz_c} !== ((n == 4) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL sweep_w16_nz_c%0d: got %b expected %b", n, {fn_c, fz_c},
                   ((n == 4) ? 2'b01 : 2'b10));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_set_flags_gating();
    test_flush();
    test_reset_mid_flight();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
